// File: rtl/addsub_pkg.sv
// addsub_pkg
//   Shared constants and types for the skewed-pipeline adder/subtractor.
//   - DEF_WIDTH / DEF_STAGES : default operand width and pipeline depth.
//   - MAX_WIDTH             : upper bound on WIDTH; stage-register data fields are
//                              sized to this so one struct serves every legal WIDTH.
//   - stage_t                : one pipeline stage register (valid, carry chain,
//                              finished sum chunks, operand chunks still to do).
package addsub_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;
  localparam int MAX_WIDTH  = 64;

  typedef struct packed {
    logic                 valid;  // stage holds a live operation
    logic                 carry;  // carry out of the chunk processed in this stage
    logic                 c_msb;  // carry into the top bit of that chunk (for ovf)
    logic [MAX_WIDTH-1:0] sum;    // finished sum chunks (low chunks only)
    logic [MAX_WIDTH-1:0] a;      // operand A chunks still waiting upstream
    logic [MAX_WIDTH-1:0] b;      // operand B chunks, already inverted for subtract
  } stage_t;

  // Subtract is a + ~b + ~borrow, so the borrow-in becomes an inverted carry-in.
  function automatic logic eff_carry_in(input logic sub_op, input logic cin);
    return sub_op ? ~cin : cin;
  endfunction

endpackage

// File: rtl/cla_chunk.sv
// cla_chunk
//   CW-bit carry-lookahead adder slice. Every carry is built directly from the
//   generate/propagate terms and cin, so there is no ripple path inside a chunk.
//   Ports:
//     a, b   : CW-bit addends
//     cin    : carry into bit 0
//     s      : CW-bit sum
//     cout   : carry out of bit CW-1
//     c_msb  : carry into bit CW-1 (used by the caller for signed overflow)
module cla_chunk #(
  parameter int CW = 8
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] s,
  output logic          cout,
  output logic          c_msb
);

  logic [CW-1:0] g;
  logic [CW-1:0] p;
  logic [CW:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // c[i] = g[i-1] | p[i-1]g[i-2] | ... | p[i-1..0]cin, expanded per bit.
  always_comb begin
    logic prop;
    c    = '0;
    prop = 1'b1;
    c[0] = cin;
    for (int i = 1; i <= CW; i++) begin
      prop = 1'b1;
      for (int j = i - 1; j >= 0; j--) begin
        c[i] = c[i] | (g[j] & prop);
        prop = prop & p[j];
      end
      c[i] = c[i] | (cin & prop);
    end
  end

  assign s     = p ^ c[CW-1:0];
  assign cout  = c[CW];
  assign c_msb = c[CW-1];

endmodule

// File: rtl/pipe_addsub.sv
// pipe_addsub
//   Skewed-pipeline adder/subtractor. Stage k adds chunk k of the operands using
//   the carry registered by stage k-1; unprocessed operand chunks and finished
//   sum chunks travel forward in the stage registers. Each stage has its own
//   valid bit and loads whenever it is empty or the next stage is loading, so
//   the pipe doubles as a STAGES-deep elastic buffer.
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset
//     in_valid, in_ready  : operand handshake
//     a, b, sub, c_in     : operands, 0=add / 1=subtract, carry/borrow in
//     out_valid, out_ready: result handshake
//     sum, c_out, ovf,zero: result, unsigned carry, signed overflow, result==0
module pipe_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = WIDTH / STAGES;

  if (WIDTH < 4 || (WIDTH % STAGES) != 0 || WIDTH > MAX_WIDTH) begin : gen_bad_params
    $error("pipe_addsub: illegal WIDTH/STAGES combination");
  end

  logic [STAGES:0] ready;
  logic            init_q;
  stage_t          last_q;

  // in_ready must stay low during reset and rise on the first edge after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) init_q <= 1'b0;
    else        init_q <= 1'b1;
  end

  assign ready[STAGES] = out_ready;
  assign in_ready      = init_q & ready[0];

  for (genvar gi = 0; gi < STAGES; gi++) begin : gen_stage
    stage_t        up;       // what feeds this stage's chunk adder
    stage_t        stage_d;
    stage_t        stage_q;
    logic [CW-1:0] s_chunk;
    logic          co;
    logic          cm;
    logic          unused_stage;

    if (gi == 0) begin : gen_head
      always_comb begin
        up       = '0;
        up.valid = in_valid & init_q;
        up.carry = eff_carry_in(sub, c_in);
        up.a     = MAX_WIDTH'(a);
        up.b     = MAX_WIDTH'(sub ? ~b : b);
      end
    end else begin : gen_body
      assign up = gen_stage[gi-1].stage_q;
    end

    cla_chunk #(.CW(CW)) u_cla (
      .a     (up.a[gi*CW +: CW]),
      .b     (up.b[gi*CW +: CW]),
      .cin   (up.carry),
      .s     (s_chunk),
      .cout  (co),
      .c_msb (cm)
    );

    always_comb begin
      stage_d                   = up;
      stage_d.sum[gi*CW +: CW]  = s_chunk;
      stage_d.carry             = co;
      stage_d.c_msb             = cm;
    end

    assign ready[gi] = ~stage_q.valid | ready[gi+1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         stage_q <= '0;
      else if (ready[gi]) stage_q <= stage_d;
    end

    // Consumed operand chunks and not-yet-written sum chunks are dead bits.
    assign unused_stage = ^stage_q;
  end

  assign last_q    = gen_stage[STAGES-1].stage_q;
  assign out_valid = last_q.valid;
  assign sum       = last_q.sum[WIDTH-1:0];
  assign c_out     = last_q.carry;
  assign ovf       = last_q.c_msb ^ last_q.carry;
  // Gated by valid so zero reads 0 out of reset, when sum is also 0.
  assign zero      = last_q.valid & ~|last_q.sum[WIDTH-1:0];

endmodule

// File: tb/tb_pipe_addsub.sv
module tb_pipe_addsub;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        c_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        c_out;
  logic        ovf;
  logic        zero;

  int errors = 0;
  int checks = 0;

  logic [34:0] q[$];      // expected {c_out, ovf, zero, sum}, FIFO order
  int          n_out = 0;
  logic        prev_stall = 1'b0;

  pipe_addsub #(.WIDTH(32), .STAGES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: plain 33-bit arithmetic, overflow from operand/result signs.
  function automatic logic [34:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic ms, input logic mc);
    logic [31:0] bb;
    logic        cc;
    logic [32:0] r;
    logic        v;
    bb = ms ? ~mb : mb;
    cc = ms ? ~mc : mc;
    r  = {1'b0, ma} + {1'b0, bb} + {32'd0, cc};
    v  = (ma[31] == bb[31]) && (r[31] != ma[31]);
    return {r[32], v, (r[31:0] == 32'd0), r[31:0]};
  endfunction

  // Scoreboard: sampled on the falling edge, inputs change 1 ns after rising.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) check("stall_keeps_valid", out_valid, 1);
        if (out_valid) begin
          check("out_has_op", q.size() != 0, 1);
          if (q.size() != 0) begin
            check($sformatf("result%0d", n_out), {c_out, ovf, zero, sum}, q[0]);
            if (out_ready) begin
              void'(q.pop_front());
              n_out++;
            end
          end
        end
        if (in_valid && in_ready) q.push_back(model(a, b, sub, c_in));
        prev_stall = out_valid && !out_ready;
      end
    end
  end

  // One op on an idle pipe; expects result exactly 4 edges after acceptance.
  task automatic do_op(input string tag, input logic [31:0] ta, input logic [31:0] tbv,
                       input logic ts, input logic tc, input logic [31:0] esum,
                       input logic ec, input logic eo, input logic ez);
    int n;
    n = 0;
    in_valid = 1'b1; a = ta; b = tbv; sub = ts; c_in = tc; out_ready = 1'b1;
    while (n < 20 && !(n > 0 && out_valid)) begin
      @(posedge clk); #1;
      if (n == 0) in_valid = 1'b0;
      n++;
    end
    check({tag, "_latency"}, n, 4);
    check({tag, "_sum"}, sum, esum);
    check({tag, "_flags"}, {c_out, ovf, zero}, {ec, eo, ez});
    $display("op %s a=%h b=%h sub=%0b cin=%0b -> sum=%h c=%0b v=%0b z=%0b", tag, ta, tbv, ts, tc,
             sum, c_out, ovf, zero);
    @(posedge clk); #1;
  endtask

  initial begin
    int   n_acc;
    int   sent;
    int   base_out;
    int   cnt;
    logic dropped;
    logic will;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; c_in = 1'b0; out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_sum", sum, 0);
    check("rst_flags", {c_out, ovf, zero}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("in_ready_before_edge", in_ready, 0);
    @(posedge clk); #1;
    check("in_ready_after_edge", in_ready, 1);

    // Directed vectors, expected values worked out by hand
    do_op("add_wrap",  32'hFFFFFFFF, 32'h00000001, 0, 0, 32'h00000000, 1, 0, 1);
    do_op("add_ovf",   32'h7FFFFFFF, 32'h00000001, 0, 0, 32'h80000000, 0, 1, 0);
    do_op("sub_5m7",   32'h00000005, 32'h00000007, 1, 0, 32'hFFFFFFFE, 0, 0, 0);
    do_op("sub_7m5b",  32'h00000007, 32'h00000005, 1, 1, 32'h00000001, 1, 0, 0);
    do_op("add_cin",   32'h12345678, 32'h0F0F0F0F, 0, 1, 32'h21436588, 0, 0, 0);
    do_op("sub_ovf",   32'h80000000, 32'h00000001, 1, 0, 32'h7FFFFFFF, 1, 1, 0);
    do_op("sub_equal", 32'h12345678, 32'h12345678, 1, 0, 32'h00000000, 1, 0, 1);
    do_op("add_chunk", 32'h000000FF, 32'h00000001, 0, 0, 32'h00000100, 0, 0, 0);

    // 10 back-to-back ops, out_ready low for cycles 3..12
    sent = 0; dropped = 1'b0; base_out = n_out;
    for (int c = 0; c < 60 && (sent < 10 || q.size() != 0); c++) begin
      out_ready = !(c >= 3 && c <= 12);
      if (sent < 10) begin
        in_valid = 1'b1;
        a = 32'h01010101 * (sent + 1);
        b = 32'hFFFFFFF0 + sent;
        sub = sent[0];
        c_in = sent[1];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && !in_ready && !dropped) begin
        dropped = 1'b1;
        check("stall_held_count", q.size(), 4);
        $display("stall: in_ready low at cycle %0d with %0d held", c, q.size());
      end
      will = in_valid && in_ready;
      @(posedge clk); #1;
      if (will) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("stall_in_ready_dropped", dropped, 1);
    check("stall_all_emitted", n_out - base_out, 10);

    // Reset with 3 ops in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 32'h100 + i; b = 32'h3; sub = 1'b0; c_in = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_valid", out_valid, 0);
    check("mid_reset_in_ready", in_ready, 0);
    check("mid_reset_sum", sum, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    check("post_reset_stale", cnt, 0);
    do_op("after_reset", 32'h00000010, 32'h00000020, 0, 1, 32'h00000031, 0, 0, 0);

    // Random run, 10k accepted ops
    n_acc = 0; base_out = n_out;
    for (int cyc = 0; cyc < 60000 && n_acc < 10000; cyc++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 3))
        0:       a = 32'hFFFFFFFF;
        1:       a = 32'h7FFFFFFF;
        default: a = $urandom;
      endcase
      b    = ($urandom_range(0, 3) == 0) ? a : $urandom;
      sub  = $urandom_range(0, 1);
      c_in = $urandom_range(0, 1);
      #1;
      will = in_valid && in_ready;
      @(posedge clk); #1;
      if (will) n_acc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("rand_accepted", n_acc, 10000);
    cnt = 0;
    while (cnt < 20 && q.size() != 0) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("rand_drained", q.size(), 0);
    check("rand_emitted", n_out - base_out, n_acc);
    $display("random: %0d ops accepted, %0d results", n_acc, n_out - base_out);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
